// File: rtl/imm_pkg.sv
// Shared widths, extension mode codes and result-register state encoding
// for the immediate-extension arbiter.
package imm_pkg;

   localparam int DEF_IN_W  = 11;
   localparam int DEF_OUT_W = 16;

   localparam logic [1:0] MODE_SEXT  = 2'b00;
   localparam logic [1:0] MODE_ZEXT  = 2'b01;
   localparam logic [1:0] MODE_UPPER = 2'b10;
   localparam logic [1:0] MODE_BOFF  = 2'b11;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extender: widens an IN_W field to OUT_W bits
// as sign-extend, zero-extend, upper-immediate or branch-offset.
module imm_extend_core
   import imm_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int OUT_W = DEF_OUT_W
) (
   input  logic [IN_W-1:0]  imm,
   input  logic [1:0]       mode,
   output logic [OUT_W-1:0] ext
);

   logic [OUT_W-1:0] sext;

   // Select the extension selected by mode; BOFF drops the top SEXT bit.
   always_comb begin
      sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
      ext  = sext;
      case (mode)
         MODE_SEXT:  ext = sext;
         MODE_ZEXT:  ext = {{(OUT_W-IN_W){1'b0}}, imm};
         MODE_UPPER: ext = {imm[OUT_W-IN_W-1:0], {IN_W{1'b0}}};
         MODE_BOFF:  ext = {sext[OUT_W-2:0], 1'b0};
         default:    ext = sext;
      endcase
   end

endmodule

// File: rtl/imm_share_arbiter.sv
// Round-robin share of one immediate extender between the ALU-operand
// requester (0) and the branch-offset requester (1), with a one-entry
// valid/ready result register toward the datapath.
//
//  state    | meaning
//  ---------+-------------------------------------------------
//  ST_EMPTY | no result held; any granted request is accepted
//  ST_FULL  | result held; new accept only if consumer drains
module imm_share_arbiter
   import imm_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int OUT_W = DEF_OUT_W
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             req0_valid,
   input  logic [IN_W-1:0]  req0_imm,
   input  logic [1:0]       req0_mode,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [IN_W-1:0]  req1_imm,
   input  logic [1:0]       req1_mode,
   output logic             req1_ready,
   output logic             res_valid,
   output logic [OUT_W-1:0] res_data,
   output logic             res_id,
   input  logic             res_ready
);

   state_e           state_q, state_d;
   logic [OUT_W-1:0] res_data_q, res_data_d;
   logic             res_id_q, res_id_d;
   logic             last_grant_q, last_grant_d;

   logic             grant_valid;
   logic             grant_id;
   logic             can_accept;
   logic             accept;
   logic [IN_W-1:0]  sel_imm;
   logic [1:0]       sel_mode;
   logic [OUT_W-1:0] ext_word;

   // Arbitration: on a tie the requester that did not win last time goes.
   // Reset blocks acceptance so nothing is handshaken in the reset cycle.
   always_comb begin
      grant_valid = req0_valid | req1_valid;
      grant_id    = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
      can_accept  = ~Reset & ((state_q == ST_EMPTY) | res_ready);
      accept      = can_accept & grant_valid;
      sel_imm     = grant_id ? req1_imm  : req0_imm;
      sel_mode    = grant_id ? req1_mode : req0_mode;
   end

   imm_extend_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_extend (
      .imm  (sel_imm),
      .mode (sel_mode),
      .ext  (ext_word)
   );

   // State and result register update.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q      <= ST_EMPTY;
         res_data_q   <= '0;
         res_id_q     <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         res_data_q   <= res_data_d;
         res_id_q     <= res_id_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Next state: accept refills (even while draining), drain empties, stall holds.
   always_comb begin
      state_d      = state_q;
      res_data_d   = res_data_q;
      res_id_d     = res_id_q;
      last_grant_d = last_grant_q;
      if (accept) begin
         state_d      = ST_FULL;
         res_data_d   = ext_word;
         res_id_d     = grant_id;
         last_grant_d = grant_id;
      end else if ((state_q == ST_FULL) && res_ready) begin
         state_d = ST_EMPTY;
      end
   end

   // Outputs: handshakes are combinational, result comes from the register.
   always_comb begin
      res_valid  = (state_q == ST_FULL);
      res_data   = res_data_q;
      res_id     = res_id_q;
      req0_ready = accept & ~grant_id;
      req1_ready = accept & grant_id;
   end

endmodule

// File: tb/tb_imm_share_arbiter.sv
// Directed bench for imm_share_arbiter, finished by a short random run
// against a behavioural model of the arbiter and result register.
module tb_imm_share_arbiter;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        req0_valid, req1_valid;
   logic [10:0] req0_imm, req1_imm;
   logic [1:0]  req0_mode, req1_mode;
   logic        req0_ready, req1_ready;
   logic        res_valid;
   logic [15:0] res_data;
   logic        res_id;
   logic        res_ready;

   int n_tests = 0;
   int n_fail  = 0;

   imm_share_arbiter dut (
      .CLK        (CLK),
      .Reset      (Reset),
      .req0_valid (req0_valid),
      .req0_imm   (req0_imm),
      .req0_mode  (req0_mode),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_imm   (req1_imm),
      .req1_mode  (req1_mode),
      .req1_ready (req1_ready),
      .res_valid  (res_valid),
      .res_data   (res_data),
      .res_id     (res_id),
      .res_ready  (res_ready)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Arithmetic formulation of the four extension modes.
   function automatic logic [15:0] ref_ext(input logic [10:0] imm, input logic [1:0] mode);
      int si;
      si = imm[10] ? int'(imm) - 2048 : int'(imm);
      case (mode)
         2'd0:    ref_ext = 16'(si);
         2'd1:    ref_ext = 16'(int'(imm));
         2'd2:    ref_ext = 16'(int'(imm) * 2048);
         default: ref_ext = 16'(si * 2);
      endcase
   endfunction

   // Single-requester vector: accepted at once, result one edge later.
   task automatic drive_one(input logic id, input logic [10:0] imm, input logic [1:0] mode,
                            input logic [15:0] exp, input string tag);
      if (id) begin
         req1_valid = 1'b1; req1_imm = imm; req1_mode = mode;
      end else begin
         req0_valid = 1'b1; req0_imm = imm; req0_mode = mode;
      end
      #1;
      chk({tag, "_ready"}, id ? req1_ready : req0_ready, 1);
      tick();
      chk({tag, "_valid"}, res_valid, 1);
      chk({tag, "_data"}, res_data, exp);
      chk({tag, "_id"}, res_id, id);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   initial begin
      logic        full_m, last_m, id_m;
      logic [15:0] data_m;
      logic        g_valid, g_id, can_m, acc0, acc1;
      int          wait0, wait1;

      Reset = 1'b1;
      req0_valid = 1'b1; req0_imm = 11'h400; req0_mode = 2'd0;
      req1_valid = 1'b1; req1_imm = 11'h000; req1_mode = 2'd1;
      res_ready = 1'b0;

      // Reset held two cycles with both requesters valid.
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_ready0", req0_ready, 0);
         chk("rst_ready1", req1_ready, 0);
         chk("rst_valid", res_valid, 0);
         chk("rst_data", res_data, 0);
         chk("rst_id", res_id, 0);
      end
      Reset = 1'b0;
      #1;
      chk("first_grant0", req0_ready, 1);
      chk("first_grant1", req1_ready, 0);
      tick();
      chk("first_data", res_data, 16'hFC00);
      chk("first_id", res_id, 0);
      #1;
      chk("full_noready0", req0_ready, 0);
      chk("full_noready1", req1_ready, 0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      res_ready = 1'b1;
      tick();
      chk("drain_valid", res_valid, 0);

      // Extension modes.
      drive_one(1'b0, 11'h400, 2'd0, 16'hFC00, "sext");
      drive_one(1'b0, 11'h400, 2'd1, 16'h0400, "zext");
      drive_one(1'b0, 11'h7FF, 2'd3, 16'hFFFE, "boff");
      drive_one(1'b0, 11'h01F, 2'd2, 16'hF800, "upper");
      drive_one(1'b0, 11'h3FF, 2'd0, 16'h03FF, "sext_pos");
      drive_one(1'b1, 11'h7FF, 2'd1, 16'h07FF, "zext_r1");
      drive_one(1'b1, 11'h001, 2'd3, 16'h0002, "boff_r1");

      // Both valid with res_ready high: alternating grants, one per cycle.
      req0_valid = 1'b1; req0_imm = 11'h123; req0_mode = 2'd1;
      req1_valid = 1'b1; req1_imm = 11'h456; req1_mode = 2'd0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_ready0", req0_ready, (i % 2) == 0);
         chk("rr_ready1", req1_ready, (i % 2) == 1);
         tick();
         chk("rr_valid", res_valid, 1);
         chk("rr_id", res_id, i % 2);
         chk("rr_data", res_data, (i % 2) ? 16'hFC56 : 16'h0123);
      end

      // Consumer stall for five cycles.
      res_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("stall_ready0", req0_ready, 0);
         chk("stall_ready1", req1_ready, 0);
         tick();
         chk("stall_valid", res_valid, 1);
         chk("stall_data", res_data, 16'hFC56);
         chk("stall_id", res_id, 1);
      end
      res_ready = 1'b1;
      #1;
      chk("unstall_ready0", req0_ready, 1);
      chk("unstall_ready1", req1_ready, 0);
      tick();
      chk("unstall_data", res_data, 16'h0123);
      chk("unstall_id", res_id, 0);

      // Reset while full and stalled.
      res_ready = 1'b0;
      req1_valid = 1'b0;
      req0_valid = 1'b1;
      Reset = 1'b1;
      #1;
      chk("rst_mid_ready0", req0_ready, 0);
      tick();
      chk("rst_mid_valid", res_valid, 0);
      chk("rst_mid_data", res_data, 0);
      Reset = 1'b0;
      req0_imm = 11'h01F; req0_mode = 2'd2;
      req1_valid = 1'b1; req1_imm = 11'h000; req1_mode = 2'd0;
      #1;
      chk("post_rst_ready0", req0_ready, 1);
      chk("post_rst_ready1", req1_ready, 0);
      tick();
      chk("post_rst_data", res_data, 16'hF800);
      chk("post_rst_id", res_id, 0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      res_ready = 1'b1;
      tick();
      chk("post_rst_drain", res_valid, 0);

      // Random traffic against a model; held requests stay stable until taken.
      full_m = 1'b0; last_m = 1'b0; id_m = 1'b0; data_m = 16'hF800;
      acc0 = 1'b0; acc1 = 1'b0;
      wait0 = 0; wait1 = 0;
      for (int c = 0; c < 300; c++) begin
         if (!(req0_valid && !acc0)) begin
            req0_valid = 1'($urandom_range(0, 1));
            req0_imm   = 11'($urandom);
            req0_mode  = 2'($urandom);
         end
         if (!(req1_valid && !acc1)) begin
            req1_valid = 1'($urandom_range(0, 1));
            req1_imm   = 11'($urandom);
            req1_mode  = 2'($urandom);
         end
         res_ready = ($urandom_range(0, 3) != 0);
         #1;
         g_valid = req0_valid | req1_valid;
         g_id    = req1_valid && (!req0_valid || last_m == 1'b0);
         can_m   = !full_m || res_ready;
         acc0    = can_m && g_valid && !g_id;
         acc1    = can_m && g_valid && g_id;
         chk("rnd_ready0", req0_ready, acc0);
         chk("rnd_ready1", req1_ready, acc1);
         if (acc0) begin
            chk("rnd_fair0", wait0 < 2, 1);
            wait0 = 0;
            if (req1_valid) wait1++;
         end
         if (acc1) begin
            chk("rnd_fair1", wait1 < 2, 1);
            wait1 = 0;
            if (req0_valid) wait0++;
         end
         tick();
         if (acc0 || acc1) begin
            full_m = 1'b1;
            id_m   = acc1;
            last_m = acc1;
            data_m = acc1 ? ref_ext(req1_imm, req1_mode) : ref_ext(req0_imm, req0_mode);
         end else if (full_m && res_ready) begin
            full_m = 1'b0;
         end
         chk("rnd_valid", res_valid, full_m);
         if (full_m) begin
            chk("rnd_data", res_data, data_m);
            chk("rnd_id", res_id, id_m);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
